// File: rtl/sram_sched_pkg.sv
// Shared widths, read latency and the in-flight read record for the SRAM port scheduler.
package sram_sched_pkg;

    localparam int ADDR_WIDTH = 11;
    localparam int DATA_WIDTH = 32;
    localparam int NUM_WMASKS = 4;
    localparam int RD_LATENCY = 2;
    localparam int IDX_WIDTH  = 2;

    typedef struct packed {
        logic                 valid;
        logic [IDX_WIDTH-1:0] idx;
    } inflight_t;

endpackage

// File: rtl/sram_sched_arbiter.sv
// Port-0 arbiter: request vector to one-hot grant plus index.
// Round-robin when SRAM_SCHED_RR_EN is defined, otherwise fixed priority (lowest index wins).
module sram_sched_arbiter
    import sram_sched_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   i_req,
    output logic [NUM_REQ-1:0]   o_grant,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic                 o_valid
);

    localparam int SLOTS = 1 << IDX_WIDTH;

    logic [SLOTS-1:0] w_req_pad;
    logic [SLOTS-1:0] w_grant_pad;

    assign o_grant = w_grant_pad[NUM_REQ-1:0];

`ifdef SRAM_SCHED_RR_EN
    // r_ptr holds the first index to consider, i.e. last grant + 1 (mod NUM_REQ).
    logic [IDX_WIDTH-1:0] r_ptr;
    logic [IDX_WIDTH:0]   w_cand;

    always_comb begin
        w_req_pad                = '0;
        w_req_pad[NUM_REQ-1:0]   = i_req;
        w_grant_pad              = '0;
        o_idx                    = '0;
        o_valid                  = 1'b0;
        w_cand                   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (IDX_WIDTH+1)'(k);
            if (w_cand >= (IDX_WIDTH+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_WIDTH+1)'(NUM_REQ);
            end
            if (!o_valid && w_req_pad[w_cand[IDX_WIDTH-1:0]]) begin
                o_valid                               = 1'b1;
                o_idx                                 = w_cand[IDX_WIDTH-1:0];
                w_grant_pad[w_cand[IDX_WIDTH-1:0]]    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (o_valid) begin
            r_ptr <= (o_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : o_idx + 1'b1;
        end
    end
`else
    logic w_unused_clk;
    assign w_unused_clk = clk ^ rst_n;

    always_comb begin
        w_req_pad                = '0;
        w_req_pad[NUM_REQ-1:0]   = i_req;
        w_grant_pad              = '0;
        o_idx                    = '0;
        o_valid                  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_valid && w_req_pad[k]) begin
                o_valid        = 1'b1;
                o_idx          = IDX_WIDTH'(k);
                w_grant_pad[k] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/sram_port_scheduler.sv
// Scheduler for a 2048x32 dual-port SRAM: arbitrated read/write port 0, read-only port 1.
// SRAM_SCHED_RR_EN selects round-robin port-0 arbitration (fixed priority otherwise).
module sram_port_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = sram_sched_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sram_sched_pkg::DATA_WIDTH,
    parameter int NUM_WMASKS = sram_sched_pkg::NUM_WMASKS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*NUM_WMASKS-1:0] req_wmask,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            rd_resp_valid,
    output logic [DATA_WIDTH-1:0]         rd_resp_data,
    input  logic                          ro_req_valid,
    output logic                          ro_req_ready,
    input  logic [ADDR_WIDTH-1:0]         ro_req_addr,
    output logic                          ro_resp_valid,
    output logic [DATA_WIDTH-1:0]         ro_resp_data,
    output logic                          sram_csb0,
    output logic                          sram_web0,
    output logic [NUM_WMASKS-1:0]         sram_wmask0,
    output logic [ADDR_WIDTH-1:0]         sram_addr0,
    output logic [DATA_WIDTH-1:0]         sram_din0,
    input  logic [DATA_WIDTH-1:0]         sram_dout0,
    output logic                          sram_csb1,
    output logic [ADDR_WIDTH-1:0]         sram_addr1,
    input  logic [DATA_WIDTH-1:0]         sram_dout1
);

    import sram_sched_pkg::*;

    // Handshakes: a transfer happens on a posedge where valid && ready are both high.
    // ready is combinational from this cycle's inputs; a requester keeps valid and its
    // payload stable until it sees ready.

    logic [NUM_REQ-1:0]    w_grant;
    logic [IDX_WIDTH-1:0]  w_gidx;
    logic                  w_gvalid;
    logic                  w_sel_we;
    logic [NUM_WMASKS-1:0] w_sel_mask;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_collide;
    logic                  w_ro_acc;
    logic [NUM_REQ-1:0]    w_rd_onehot;

    inflight_t             r_p0_pipe [RD_LATENCY];
    logic [RD_LATENCY-1:0] r_ro_pipe;

    sram_sched_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (req_valid),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_valid (w_gvalid)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_sel_we   = 1'b0;
        w_sel_mask = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_sel_we   = req_we[k];
                w_sel_mask = req_wmask[k*NUM_WMASKS +: NUM_WMASKS];
                w_sel_addr = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_data = req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // A same-address port-1 read waits one cycle so it observes the port-0 write.
    assign w_collide    = w_gvalid && w_sel_we && (ro_req_addr == w_sel_addr);
    assign ro_req_ready = ~w_collide;
    assign w_ro_acc     = ro_req_valid && ro_req_ready;

    always_comb begin
        w_rd_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_p0_pipe[RD_LATENCY-1].idx == IDX_WIDTH'(k)) begin
                w_rd_onehot[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_csb0     <= 1'b1;
            sram_web0     <= 1'b1;
            sram_wmask0   <= '0;
            sram_addr0    <= '0;
            sram_din0     <= '0;
            sram_csb1     <= 1'b1;
            sram_addr1    <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                r_p0_pipe[k] <= '0;
            end
            r_ro_pipe     <= '0;
            rd_resp_valid <= '0;
            rd_resp_data  <= '0;
            ro_resp_valid <= 1'b0;
            ro_resp_data  <= '0;
        end else begin
            sram_csb0 <= ~w_gvalid;
            if (w_gvalid) begin
                sram_web0   <= ~w_sel_we;
                sram_wmask0 <= w_sel_mask;
                sram_addr0  <= w_sel_addr;
                sram_din0   <= w_sel_data;
            end
            sram_csb1 <= ~w_ro_acc;
            if (w_ro_acc) begin
                sram_addr1 <= ro_req_addr;
            end

            r_p0_pipe[0] <= '{valid: w_gvalid & ~w_sel_we, idx: w_gidx};
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_p0_pipe[k] <= r_p0_pipe[k-1];
            end
            r_ro_pipe <= {r_ro_pipe[RD_LATENCY-2:0], w_ro_acc};

            // Capture only when a read is due, so idle-cycle X from the macro never lands.
            rd_resp_valid <= r_p0_pipe[RD_LATENCY-1].valid ? w_rd_onehot : '0;
            if (r_p0_pipe[RD_LATENCY-1].valid) begin
                rd_resp_data <= sram_dout0;
            end
            ro_resp_valid <= r_ro_pipe[RD_LATENCY-1];
            if (r_ro_pipe[RD_LATENCY-1]) begin
                ro_resp_data <= sram_dout1;
            end
        end
    end

endmodule

// File: tb/tb_sram_port_scheduler.sv
// Directed bench for sram_port_scheduler with a behavioral dual-port SRAM model.
// Expected arbitration depends on SRAM_SCHED_RR_EN.
module tb_sram_port_scheduler;

    localparam int NR = 2;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int MW = 4;

    logic               clk;
    logic               rst_n;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR-1:0]      req_we;
    logic [NR*MW-1:0]   req_wmask;
    logic [NR*AW-1:0]   req_addr;
    logic [NR*DW-1:0]   req_wdata;
    logic [NR-1:0]      rd_resp_valid;
    logic [DW-1:0]      rd_resp_data;
    logic               ro_req_valid;
    logic               ro_req_ready;
    logic [AW-1:0]      ro_req_addr;
    logic               ro_resp_valid;
    logic [DW-1:0]      ro_resp_data;
    logic               sram_csb0;
    logic               sram_web0;
    logic [MW-1:0]      sram_wmask0;
    logic [AW-1:0]      sram_addr0;
    logic [DW-1:0]      sram_din0;
    logic [DW-1:0]      sram_dout0;
    logic               sram_csb1;
    logic [AW-1:0]      sram_addr1;
    logic [DW-1:0]      sram_dout1;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    sram_port_scheduler #(
        .NUM_REQ    (NR),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WMASKS (MW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_wmask     (req_wmask),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_data  (rd_resp_data),
        .ro_req_valid  (ro_req_valid),
        .ro_req_ready  (ro_req_ready),
        .ro_req_addr   (ro_req_addr),
        .ro_resp_valid (ro_resp_valid),
        .ro_resp_data  (ro_resp_data),
        .sram_csb0     (sram_csb0),
        .sram_web0     (sram_web0),
        .sram_wmask0   (sram_wmask0),
        .sram_addr0    (sram_addr0),
        .sram_din0     (sram_din0),
        .sram_dout0    (sram_dout0),
        .sram_csb1     (sram_csb1),
        .sram_addr1    (sram_addr1),
        .sram_dout1    (sram_dout1)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Macro model: inputs latched at posedge, array access at the following negedge.
    logic [DW-1:0] mem [0:2047];
    logic          m_csb0, m_web0, m_csb1;
    logic [MW-1:0] m_wmask0;
    logic [AW-1:0] m_addr0, m_addr1;
    logic [DW-1:0] m_din0;

    always @(posedge clk) begin
        m_csb0   <= sram_csb0;
        m_web0   <= sram_web0;
        m_wmask0 <= sram_wmask0;
        m_addr0  <= sram_addr0;
        m_din0   <= sram_din0;
        m_csb1   <= sram_csb1;
        m_addr1  <= sram_addr1;
    end

    always @(negedge clk) begin
        if (m_csb0 === 1'b0 && m_web0 === 1'b0) begin
            for (int b = 0; b < MW; b++) begin
                if (m_wmask0[b]) mem[m_addr0][b*8 +: 8] <= m_din0[b*8 +: 8];
            end
        end
        sram_dout0 <= (m_csb0 === 1'b0 && m_web0 === 1'b1) ? mem[m_addr0] : 'x;
        sram_dout1 <= (m_csb1 === 1'b0) ? mem[m_addr1] : 'x;
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic p0_req(input int r, input bit we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [MW-1:0] m);
        req_valid            = '0;
        req_valid[r]         = 1'b1;
        req_we[r]            = we;
        req_addr[r*AW +: AW] = a;
        req_wdata[r*DW +: DW] = d;
        req_wmask[r*MW +: MW] = m;
    endtask

    task automatic p0_idle();
        req_valid = '0;
    endtask

    // Scoreboard check
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [NR-1:0] exp_g [4];
    logic [DW-1:0] exp_d;

    initial begin
        rst_n        = 1'b0;
        req_valid    = '0;
        req_we       = '0;
        req_wmask    = '0;
        req_addr     = '0;
        req_wdata    = '0;
        ro_req_valid = 1'b0;
        ro_req_addr  = '0;
`ifdef SRAM_SCHED_RR_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

        // Reset state
        repeat (3) tick();
        chk("rst_csb0", sram_csb0, 1'b1);
        chk("rst_csb1", sram_csb1, 1'b1);
        chk("rst_web0", sram_web0, 1'b1);
        chk("rst_wmask0", sram_wmask0, 4'h0);
        chk("rst_addr0", sram_addr0, 11'h0);
        chk("rst_din0", sram_din0, 32'h0);
        chk("rst_rd_valid", rd_resp_valid, 2'b00);
        chk("rst_rd_data", rd_resp_data, 32'h0);
        chk("rst_ro_valid", ro_resp_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Write by req0, read back by req1
        p0_req(0, 1'b1, 11'h005, 32'hDEADBEEF, 4'hF);
        #1 chk("wr_ready", req_ready, 2'b01);
        tick();
        chk("wr_csb0", sram_csb0, 1'b0);
        chk("wr_web0", sram_web0, 1'b0);
        chk("wr_addr0", sram_addr0, 11'h005);
        chk("wr_din0", sram_din0, 32'hDEADBEEF);
        chk("wr_wmask0", sram_wmask0, 4'hF);
        p0_req(1, 1'b0, 11'h005, 32'h0, 4'h0);
        #1 chk("rd_ready", req_ready, 2'b10);
        tick();
        chk("rd_csb0", sram_csb0, 1'b0);
        chk("rd_web0", sram_web0, 1'b1);
        p0_idle();
        tick();
        chk("idle_csb0", sram_csb0, 1'b1);
        chk("idle_addr0_hold", sram_addr0, 11'h005);
        chk("rd1_valid_early", rd_resp_valid, 2'b00);
        tick();
        chk("rd1_valid", rd_resp_valid, 2'b10);
        chk("rd1_data", rd_resp_data, 32'hDEADBEEF);
        tick();
        chk("rd1_pulse_end", rd_resp_valid, 2'b00);
        chk("rd1_data_hold", rd_resp_data, 32'hDEADBEEF);

        // Byte mask
        p0_req(0, 1'b1, 11'h020, 32'h11223344, 4'hF);
        tick();
        p0_req(1, 1'b1, 11'h020, 32'hAABBCCDD, 4'h2);
        tick();
        p0_req(0, 1'b0, 11'h020, 32'h0, 4'h0);
        tick();
        p0_idle();
        tick();
        tick();
        chk("mask_valid", rd_resp_valid, 2'b01);
        chk("mask_data", rd_resp_data, 32'h1122CC44);

        // Port-1 collision with a same-address write
        p0_req(0, 1'b1, 11'h7FF, 32'h00000001, 4'hF);
        ro_req_valid = 1'b1;
        ro_req_addr  = 11'h7FF;
        #1 chk("col_ro_ready", ro_req_ready, 1'b0);
        tick();
        chk("col_csb1_blocked", sram_csb1, 1'b1);
        p0_idle();
        #1 chk("col_ro_ready_next", ro_req_ready, 1'b1);
        tick();
        chk("col_csb1_issue", sram_csb1, 1'b0);
        chk("col_addr1", sram_addr1, 11'h7FF);
        ro_req_valid = 1'b0;
        tick();
        tick();
        chk("col_ro_valid", ro_resp_valid, 1'b1);
        chk("col_ro_data", ro_resp_data, 32'h00000001);
        tick();
        chk("col_ro_pulse_end", ro_resp_valid, 1'b0);

        // Same address but port-0 read: no stall
        p0_req(0, 1'b0, 11'h7FF, 32'h0, 4'h0);
        ro_req_valid = 1'b1;
        #1 chk("rdrd_ro_ready", ro_req_ready, 1'b1);
        // Different address write: no stall
        p0_req(0, 1'b1, 11'h100, 32'hCAFE0000, 4'hF);
        #1 chk("diff_ro_ready", ro_req_ready, 1'b1);
        tick();
        p0_idle();
        ro_req_valid = 1'b0;
        tick();
        tick();
        chk("diff_ro_valid", ro_resp_valid, 1'b1);
        chk("diff_ro_data", ro_resp_data, 32'h00000001);
        tick();

        // Streaming: preload value = addr, then 8 back-to-back reads
        for (int i = 0; i < 8; i++) begin
            p0_req(i % 2, 1'b1, AW'(i), DW'(i), 4'hF);
            tick();
        end
        for (int i = 0; i < 8; i++) begin
            p0_req(1, 1'b0, AW'(i), 32'h0, 4'h0);
            exp_q.push_back(DW'(i));
            tick();
            if (i >= 2) begin
                chk("stream_valid", rd_resp_valid, 2'b10);
                chk("stream_data", rd_resp_data, exp_q.pop_front());
            end
        end
        p0_idle();
        for (int n = 0; n < 4 && exp_q.size() > 0; n++) begin
            tick();
            chk("stream_valid", rd_resp_valid, 2'b10);
            chk("stream_data", rd_resp_data, exp_q.pop_front());
        end
        chk("stream_drained", exp_q.size(), 0);
        tick();
        chk("stream_end", rd_resp_valid, 2'b00);

        // Reset asserted with a read in flight
        p0_req(0, 1'b0, 11'h003, 32'h0, 4'h0);
        tick();
        chk("mid_csb0_active", sram_csb0, 1'b0);
        p0_idle();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_csb0", sram_csb0, 1'b1);
        chk("mid_rst_csb1", sram_csb1, 1'b1);
        chk("mid_rst_valid", rd_resp_valid, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("mid_no_resp", rd_resp_valid, 2'b00);
        end
        chk("mid_data_cleared", rd_resp_data, 32'h0);

        // Arbitration: both requesters reading (addr 1 -> 1, addr 2 -> 2)
        req_we                = '0;
        req_addr[0*AW +: AW]  = 11'h001;
        req_addr[1*AW +: AW]  = 11'h002;
        req_valid             = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1 chk("arb_grant", req_ready, exp_g[c]);
            tick();
            chk("arb_addr0", sram_addr0, (exp_g[c] == 2'b01) ? 11'h001 : 11'h002);
            if (c >= 2) begin
                exp_d = (exp_g[c-2] == 2'b01) ? 32'h1 : 32'h2;
                chk("arb_resp_idx", rd_resp_valid, exp_g[c-2]);
                chk("arb_resp_data", rd_resp_data, exp_d);
            end
        end
        p0_idle();
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
